rcv_frame_ctrl: RTL and testbench
=================================

RCV_FRAME_CTRL -- requirements
Module: rcv_frame_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10: clock cycles per serial bit; legal range 4..255.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 serial_in  input  1  asynchronous serial line; idles high.
REQ-006 data_read  input  1  consumer acknowledge; single-cycle pulse.
REQ-007 rx_data  output  DATA_BITS  last correctly received payload, LSB-aligned.
REQ-008 data_ready  output  1  rx_data holds an unread frame.
REQ-009 overrun_error  output  1  frame loaded while the previous one was unread.
REQ-010 framing_error  output  1  last frame had stop bit = 0.
REQ-011 parity_error  output  1  last frame failed parity check; port always present.

Function
REQ-012 serial_in SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-013 A start edge SHALL be a synchronized 1->0 transition detected in IDLE; the detect cycle is E.
REQ-014 States SHALL be IDLE, START_CHK, DATA, PARITY, STOP, LOAD, WAIT_IDLE.
REQ-015 An internal bit timer SHALL be cleared at E; start bit sampled at E+floor(CLKS_PER_BIT/2).
REQ-016 Start sample = 1 SHALL be a false start: return to IDLE, no output changes.
REQ-017 Start sample = 0 SHALL clear framing_error and parity_error and enter DATA.
REQ-018 Data bit i (i=0..DATA_BITS-1) SHALL be sampled at E+floor(CLKS_PER_BIT/2)+(i+1)*CLKS_PER_BIT, LSB first, into a shift register.
REQ-019 Stop bit SHALL be sampled one further CLKS_PER_BIT after the last data bit (or after parity when enabled).
REQ-020 Stop = 1 SHALL enter LOAD; the cycle after the stop sample, rx_data takes the shift register and data_ready = 1.
REQ-021 Stop = 0 SHALL set framing_error, leave rx_data/data_ready unchanged, and enter WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL return to IDLE only once the synchronized line reads 1.
REQ-023 LOAD SHALL return to IDLE the following cycle; a start edge is accepted in that IDLE cycle.
REQ-024 data_read with data_ready = 1 SHALL clear data_ready and overrun_error next cycle; data_read with data_ready = 0 SHALL be ignored.
REQ-025 LOAD with data_ready = 1 and no data_read that cycle SHALL set overrun_error; rx_data is overwritten.
REQ-026 LOAD coincident with data_read SHALL leave data_ready = 1, overrun_error unchanged.
REQ-027 Frame counts SHALL wrap the bit counter only through explicit state transitions, never by arithmetic overflow.

Reset
REQ-028 On n_rst low: state IDLE, rx_data = 0, data_ready = 0, all error flags 0, timer and bit counter 0, synchronizer flops 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release the first frame is received only on a new start edge.

Configuration
REQ-030 Macro RCV_PARITY_EN defined: one even-parity bit follows the data bits (PARITY state); mismatch sets parity_error; frame still loads if stop = 1.
REQ-031 Macro RCV_PARITY_EN undefined: PARITY state unreachable, frame has no parity bit, parity_error tied 0.

Verification (CLKS_PER_BIT=10, DATA_BITS=8)
REQ-032 Frame 0xA5, stop 1 -> rx_data = 0xA5, data_ready = 1 one cycle after stop sample, all errors 0.
REQ-033 Two frames 0x3C then 0xC3, no data_read -> rx_data = 0xC3, overrun_error = 1; data_read pulse -> data_ready = 0, overrun_error = 0.
REQ-034 Frame 0x55 with stop 0 -> framing_error = 1, data_ready unchanged; line held low 30 cycles -> stays WAIT_IDLE; next good frame 0x01 -> framing_error cleared at start confirm, rx_data = 0x01.
REQ-035 Low glitch of 3 cycles on idle line -> false start, no output change.
REQ-036 n_rst pulsed during data bit 4 of 0xFF -> all outputs 0; subsequent frame 0x81 received correctly.
REQ-037 RCV_PARITY_EN defined, frame 0x07 with parity bit 0 -> parity_error = 1, rx_data = 0x07, data_ready = 1.

Source files
------------

// File: rtl/rcv_frame_ctrl.sv
// Serial frame receiver: start/data/[parity]/stop sampling at bit centres, loads rx_data one cycle after the stop sample.
// Optional even parity bit when RCV_PARITY_EN is defined; otherwise parity_error is tied low.
module rcv_frame_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 parity_error
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [7:0]    HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    BIT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START_CHK, DATA, PARITY, STOP, LOAD, WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [7:0]           timer_q, timer_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 data_ready_q, data_ready_d;
  logic                 overrun_q, overrun_d;
  logic                 framing_q, framing_d;

  logic line, start_edge, tick_half, tick_bit, last_bit, load, start_ok;

  assign line       = sync2_q;
  assign start_edge = prev_q & ~sync2_q;
  assign tick_half  = (timer_q == HALF_LAST);
  assign tick_bit   = (timer_q == BIT_LAST);
  assign last_bit   = (bit_cnt_q == LAST_BIT);
  assign start_ok   = (state_q == START_CHK) && tick_half && !line;
  assign load       = (state_q == STOP) && tick_bit && line;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_edge) state_d = START_CHK;
      START_CHK: if (tick_half)  state_d = line ? IDLE : DATA;
`ifdef RCV_PARITY_EN
      DATA:      if (tick_bit && last_bit) state_d = PARITY;
`else
      DATA:      if (tick_bit && last_bit) state_d = STOP;
`endif
      PARITY:    if (tick_bit) state_d = STOP;
      STOP:      if (tick_bit) state_d = line ? LOAD : WAIT_IDLE;
      LOAD:      state_d = IDLE;
      WAIT_IDLE: if (line) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Timer restarts on every sample so each bit is timed from the previous centre.
  always_comb begin
    timer_d      = 8'd0;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;
    case (state_q)
      START_CHK:           timer_d = tick_half ? 8'd0 : timer_q + 8'd1;
      DATA, PARITY, STOP:  timer_d = tick_bit  ? 8'd0 : timer_q + 8'd1;
      default:             timer_d = 8'd0;
    endcase
    if (state_q == IDLE) bit_cnt_d = '0;
    if (state_q == DATA && tick_bit) begin
      shift_d   = {line, shift_q[DATA_BITS-1:1]};
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + CW'(1);
    end
    if (start_ok) framing_d = 1'b0;
    if (state_q == STOP && tick_bit && !line) framing_d = 1'b1;
    if (load) begin
      rx_data_d    = shift_q;
      data_ready_d = 1'b1;
      if (data_ready_q && !data_read) overrun_d = 1'b1;
    end else if (data_read && data_ready_q) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      timer_q      <= 8'd0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
    end else begin
      sync1_q      <= serial_in;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      framing_q    <= framing_d;
    end
  end

`ifdef RCV_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (start_ok) parity_d = 1'b0;
    if (state_q == PARITY && tick_bit) parity_d = (^shift_q) ^ line;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign parity_error = parity_q;
`else
  assign parity_error = 1'b0;
`endif

  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;

endmodule

// File: tb/tb_rcv_frame_ctrl.sv
// Directed bench for rcv_frame_ctrl at CLKS_PER_BIT=10, DATA_BITS=8.
module tb_rcv_frame_ctrl;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       serial_in = 1'b1;
  logic       data_read = 1'b0;
  logic [7:0] rx_data;
  logic       data_ready, overrun_error, framing_error, parity_error;

  int   n_checks = 0;
  int   n_errors = 0;
  logic dr_pre, dr_post, fe_mid;

  rcv_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    idle(1);
    data_read = 1'b0;
    idle(1);
  endtask

  // Drives one frame bit-by-bit; the stop sample lands in cycle nb*CPB-3 after the start drive.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input bit with_par, input int read_cyc, input int abort_cyc);
    logic [10:0] fb;
    int nb;
    int cyc;
    nb = with_par ? 11 : 10;
    fb = '1;
    fb[0] = 1'b0;
    fb[8:1] = d;
    if (with_par) begin
      fb[9]  = par;
      fb[10] = stop;
    end else begin
      fb[9] = stop;
    end
    cyc = 0;
    for (int c = 0; c < nb * CPB; c++) begin
      if (c % CPB == 0) serial_in = fb[4'(c / CPB)];
      @(posedge clk);
      #1;
      cyc++;
      data_read = (cyc == read_cyc);
      if (cyc == 10) fe_mid = framing_error;
      if (cyc == nb * CPB - 3) dr_pre = data_ready;
      if (cyc == nb * CPB - 2) dr_post = data_ready;
      if (cyc == abort_cyc) break;
    end
    data_read = 1'b0;
  endtask

  initial begin
    idle(3);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset data_ready", 8'(data_ready), 8'd0);
    chk("reset overrun", 8'(overrun_error), 8'd0);
    chk("reset framing", 8'(framing_error), 8'd0);
    chk("reset parity", 8'(parity_error), 8'd0);
    n_rst = 1'b1;
    idle(2);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("A5 ready before load", 8'(dr_pre), 8'd0);
    chk("A5 ready after load", 8'(dr_post), 8'd1);
    chk("A5 rx_data", rx_data, 8'hA5);
    chk("A5 overrun", 8'(overrun_error), 8'd0);
    chk("A5 framing", 8'(framing_error), 8'd0);
    chk("A5 parity", 8'(parity_error), 8'd0);
    pulse_read();
    chk("read clears ready", 8'(data_ready), 8'd0);
    chk("rx_data held after read", rx_data, 8'hA5);
    pulse_read();
    chk("idle read ready", 8'(data_ready), 8'd0);
    chk("idle read overrun", 8'(overrun_error), 8'd0);
    idle(5);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("3C rx_data", rx_data, 8'h3C);
    chk("3C overrun", 8'(overrun_error), 8'd0);
    idle(3);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("C3 rx_data", rx_data, 8'hC3);
    chk("C3 ready", 8'(data_ready), 8'd1);
    chk("C3 overrun", 8'(overrun_error), 8'd1);
    pulse_read();
    chk("read clears ready ovr", 8'(data_ready), 8'd0);
    chk("read clears overrun", 8'(overrun_error), 8'd0);
    idle(5);

    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("55 framing", 8'(framing_error), 8'd1);
    chk("55 ready unchanged", 8'(data_ready), 8'd0);
    chk("55 rx_data unchanged", rx_data, 8'hC3);
    idle(30);
    chk("low hold framing", 8'(framing_error), 8'd1);
    chk("low hold ready", 8'(data_ready), 8'd0);
    serial_in = 1'b1;
    idle(5);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("01 framing cleared at start", 8'(fe_mid), 8'd0);
    chk("01 rx_data", rx_data, 8'h01);
    chk("01 ready", 8'(data_ready), 8'd1);
    chk("01 framing", 8'(framing_error), 8'd0);
    idle(5);

    serial_in = 1'b0;
    idle(3);
    serial_in = 1'b1;
    idle(20);
    chk("glitch rx_data", rx_data, 8'h01);
    chk("glitch ready", 8'(data_ready), 8'd1);
    chk("glitch framing", 8'(framing_error), 8'd0);
    chk("glitch overrun", 8'(overrun_error), 8'd0);

    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 97, 0);
    chk("coincident rx_data", rx_data, 8'h5A);
    chk("coincident ready", 8'(data_ready), 8'd1);
    chk("coincident overrun", 8'(overrun_error), 8'd0);
    idle(5);

    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0, 44);
    n_rst = 1'b0;
    #2;
    chk("midframe rst rx_data", rx_data, 8'h00);
    chk("midframe rst ready", 8'(data_ready), 8'd0);
    chk("midframe rst overrun", 8'(overrun_error), 8'd0);
    chk("midframe rst framing", 8'(framing_error), 8'd0);
    chk("midframe rst parity", 8'(parity_error), 8'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(120);
    chk("no phantom frame", 8'(data_ready), 8'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("81 rx_data", rx_data, 8'h81);
    chk("81 ready", 8'(data_ready), 8'd1);
    chk("81 framing", 8'(framing_error), 8'd0);
    chk("81 overrun", 8'(overrun_error), 8'd0);
    pulse_read();
    idle(5);

`ifdef RCV_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0, 0);
    chk("07 bad parity flag", 8'(parity_error), 8'd1);
    chk("07 rx_data", rx_data, 8'h07);
    chk("07 ready", 8'(data_ready), 8'd1);
    pulse_read();
    idle(5);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 0, 0);
    chk("03 good parity flag", 8'(parity_error), 8'd0);
    chk("03 rx_data", rx_data, 8'h03);
`else
    chk("parity tied low", 8'(parity_error), 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
